// File: rtl/jtag_cmd_seq_if.sv
// Command, TDI byte and TDO byte handshake channels of the JTAG command sequencer.
// The master side issues commands and supplies/consumes bytes; the sequencer is the slave.
interface jtag_cmd_seq_if #(
    parameter int NBITS_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [NBITS_W-1:0] cmd_nbits;

    logic               din_valid;
    logic               din_ready;
    logic [7:0]         din_data;

    logic               dout_valid;
    logic               dout_ready;
    logic [7:0]         dout_data;

    modport master (
        output cmd_valid, cmd_op, cmd_nbits, din_valid, din_data, dout_ready,
        input  cmd_ready, din_ready, dout_valid, dout_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_nbits, din_valid, din_data, dout_ready,
        output cmd_ready, din_ready, dout_valid, dout_data
    );
endinterface

// File: rtl/jtag_cmd_seq.sv
// JTAG command sequencer: turns RESET / TMS_SEQ / SCAN / SCAN_FLIP_TMS commands into
// divided TCK bit cycles, streaming TDI/TMS bits from bytes and packing captured TDO bits.
module jtag_cmd_seq #(
    parameter int TCK_DIV = 4,
    parameter int NBITS_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    jtag_cmd_seq_if.slave bus,
    output logic          tck,
    output logic          tms,
    output logic          tdi,
    input  logic          tdo,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOW,
        S_HIGH,
        S_PUSH,
        S_DONE
    } state_t;

    localparam logic [1:0]         OP_RESET   = 2'd0;
    localparam logic [1:0]         OP_TMS     = 2'd1;
    localparam logic [1:0]         OP_SCAN    = 2'd2;
    localparam logic [7:0]         DIV_LAST   = 8'(TCK_DIV - 1);
    localparam logic [NBITS_W-1:0] NB_ONE     = NBITS_W'(1);
    localparam logic [NBITS_W-1:0] RESET_BITS = NBITS_W'(6);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         op_q;
    logic [NBITS_W-1:0] total_q;
    logic [NBITS_W-1:0] bit_cnt;
    logic [NBITS_W-1:0] bit_nxt;
    logic [7:0]         div_cnt;
    logic [7:0]         din_byte;
    logic [7:0]         cap_byte;
    logic [7:0]         dout_q;
    logic               tms_q;
    logic               tdi_q;
    logic               tms_nxt;
    logic               tdi_nxt;
    logic               accept;
    logic               advance;
    logic               push_load;
    logic               div_done;
    logic               is_last;
    logic               is_last_nxt;
    logic               uses_din;
    logic               is_scan;

    // Pin value for one bit given the op, its data bit and whether it is the final bit.
    function automatic logic pin_tms(input logic [1:0] op, input logic dbit, input logic last);
        case (op)
            OP_RESET: return !last;
            OP_TMS:   return dbit;
            OP_SCAN:  return 1'b0;
            default:  return last;
        endcase
    endfunction

    function automatic logic pin_tdi(input logic [1:0] op, input logic dbit);
        return op[1] & dbit;
    endfunction

    assign accept      = (state == S_IDLE) && bus.cmd_valid;
    assign div_done    = (div_cnt == DIV_LAST);
    assign bit_nxt     = bit_cnt + NB_ONE;
    assign is_last     = (bit_cnt == total_q - NB_ONE);
    assign is_last_nxt = (bit_nxt == total_q - NB_ONE);
    assign uses_din    = (op_q != OP_RESET);
    assign is_scan     = op_q[1];

    assign bus.cmd_ready  = (state == S_IDLE);
    assign bus.din_ready  = (state == S_FETCH);
    assign bus.dout_valid = (state == S_PUSH);
    assign bus.dout_data  = dout_q;
    assign busy           = (state != S_IDLE);
    assign tck            = (state == S_HIGH);
    assign tms            = tms_q;
    assign tdi            = tdi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            tms_q <= 1'b0;
            tdi_q <= 1'b0;
        end else begin
            state <= state_nxt;
            tms_q <= tms_nxt;
            tdi_q <= tdi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tms_nxt   = tms_q;
        tdi_nxt   = tdi_q;
        advance   = 1'b0;
        push_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == OP_RESET) begin
                        state_nxt = S_LOW;
                        tms_nxt   = 1'b1;
                        tdi_nxt   = 1'b0;
                    end else if (bus.cmd_nbits == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (bus.din_valid) begin
                    state_nxt = S_LOW;
                    tms_nxt   = pin_tms(op_q, bus.din_data[0], is_last);
                    tdi_nxt   = pin_tdi(op_q, bus.din_data[0]);
                end
            end
            S_LOW: begin
                if (div_done) begin
                    state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (div_done) begin
                    if (is_scan && ((bit_cnt[2:0] == 3'd7) || is_last)) begin
                        state_nxt = S_PUSH;
                        push_load = 1'b1;
                    end else if (is_last) begin
                        state_nxt = S_DONE;
                    end else if (uses_din && (bit_nxt[2:0] == 3'd0)) begin
                        state_nxt = S_FETCH;
                        advance   = 1'b1;
                    end else begin
                        state_nxt = S_LOW;
                        advance   = 1'b1;
                        tms_nxt   = pin_tms(op_q, din_byte[bit_nxt[2:0]], is_last_nxt);
                        tdi_nxt   = pin_tdi(op_q, din_byte[bit_nxt[2:0]]);
                    end
                end
            end
            S_PUSH: begin
                // A non-final push always lands on a byte boundary, so the next bit needs a fetch.
                if (bus.dout_ready) begin
                    if (is_last) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FETCH;
                        advance   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (state_nxt == S_DONE) begin
            tms_nxt = 1'b0;
            tdi_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_RESET;
            total_q  <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            din_byte <= '0;
            cap_byte <= '0;
            dout_q   <= '0;
        end else begin
            div_cnt <= ((state == S_LOW || state == S_HIGH) && !div_done) ? div_cnt + 8'd1 : 8'd0;
            if (accept) begin
                op_q     <= bus.cmd_op;
                total_q  <= (bus.cmd_op == OP_RESET) ? RESET_BITS : bus.cmd_nbits;
                bit_cnt  <= '0;
                cap_byte <= '0;
            end
            if (state == S_FETCH && bus.din_valid) begin
                din_byte <= bus.din_data;
            end
            // TDO is captured on the edge that raises TCK.
            if (state == S_LOW && div_done) begin
                cap_byte[bit_cnt[2:0]] <= tdo;
            end
            if (push_load) begin
                dout_q   <= cap_byte;
                cap_byte <= '0;
            end
            if (advance) begin
                bit_cnt <= bit_nxt;
            end
        end
    end

endmodule

// File: tb/tb_jtag_cmd_seq.sv
// Randomized scoreboard bench for jtag_cmd_seq: expected pin bits and TDO bytes are queued
// from a bit-level model per command and popped by monitors as the DUT produces them.
module tb_jtag_cmd_seq;

    localparam int TCK_DIV = 2;
    localparam int NBITS_W = 16;
    localparam int RESET_BUSY = 6 * 2 * TCK_DIV + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tck, tms, tdi, tdo, busy;
    logic tdo_flip = 1'b0;

    jtag_cmd_seq_if #(.NBITS_W(NBITS_W)) bus ();

    jtag_cmd_seq #(.TCK_DIV(TCK_DIV), .NBITS_W(NBITS_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .tck  (tck),
        .tms  (tms),
        .tdi  (tdi),
        .tdo  (tdo),
        .busy (busy)
    );

    always #5 clk = ~clk;

    assign tdo = tdi ^ tdo_flip;

    int n_checks = 0;
    int n_pass = 0;

    logic [1:0] pin_q[$];
    logic [7:0] dout_q[$];
    logic [7:0] din_q[$];
    logic [7:0] fixed_bytes[$];
    int din_delay = 0;
    bit dout_stall_mode = 1'b0;
    int tck_rises = 0;

    task automatic check_output(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check_output(bus.cmd_ready == 1'b1, {tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check_output(busy == 1'b0, {tag, "_busy"}, busy, 0);
        check_output(tck == 1'b0, {tag, "_tck"}, tck, 0);
        check_output(tms == 1'b0, {tag, "_tms"}, tms, 0);
        check_output(tdi == 1'b0, {tag, "_tdi"}, tdi, 0);
        check_output(bus.din_ready == 1'b0, {tag, "_din_ready"}, bus.din_ready, 0);
        check_output(bus.dout_valid == 1'b0, {tag, "_dout_valid"}, bus.dout_valid, 0);
        check_output(bus.dout_data == 8'h00, {tag, "_dout_data"}, bus.dout_data, 0);
    endtask

    // Reference model: per-bit pin values and packed TDO bytes straight from the op rules.
    task automatic apply_stimulus(input logic [1:0] op, input int nbits, input bit flip);
        int n_bits;
        int n_bytes;
        logic [7:0] bytes[$];
        logic [7:0] b;
        logic [7:0] v;
        logic d, tm, td;
        bit accepted;
        n_bits  = (op == 2'd0) ? 6 : nbits;
        n_bytes = (op == 2'd0) ? 0 : (nbits + 7) / 8;
        for (int j = 0; j < n_bytes; j++) begin
            if (fixed_bytes.size() > 0) b = fixed_bytes.pop_front();
            else b = 8'($urandom);
            bytes.push_back(b);
        end
        for (int i = 0; i < n_bits; i++) begin
            d = 1'b0;
            if (op != 2'd0) begin
                b = bytes[i / 8];
                d = b[i % 8];
            end
            case (op)
                2'd0:    begin tm = (i < 5);          td = 1'b0; end
                2'd1:    begin tm = d;                td = 1'b0; end
                2'd2:    begin tm = 1'b0;             td = d;    end
                default: begin tm = (i == n_bits - 1); td = d;    end
            endcase
            pin_q.push_back({tm, td});
        end
        if (op[1]) begin
            for (int j = 0; j < n_bytes; j++) begin
                v = 8'h00;
                b = bytes[j];
                for (int k = 0; k < 8; k++) begin
                    if (j * 8 + k < n_bits) v[k] = b[k] ^ flip;
                end
                dout_q.push_back(v);
            end
        end
        tdo_flip = flip;
        foreach (bytes[j]) din_q.push_back(bytes[j]);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_nbits = NBITS_W'(nbits);
        accepted = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        check_output(accepted, "cmd_accept", accepted, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_nbits = NBITS_W'($urandom);
    endtask

    task automatic wait_done(input int exp_busy);
        int cyc;
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
        end
        check_output(!busy, "cmd_timeout", busy, 0);
        if (exp_busy >= 0) check_output(cyc == exp_busy, "busy_cycles", cyc, exp_busy);
        check_output(pin_q.size() == 0, "pin_bits_left", pin_q.size(), 0);
        check_output(dout_q.size() == 0, "dout_bytes_left", dout_q.size(), 0);
        check_output(din_q.size() == 0, "din_bytes_left", din_q.size(), 0);
    endtask

    // Monitor: pins at each TCK rise, TCK high width, fetch/push stalls and the dout channel.
    logic tck_prev = 1'b0;
    bit stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int high_len = 0;
    always @(negedge clk) begin
        logic [1:0] e;
        logic [7:0] ed;
        if (tck && !tck_prev) begin
            tck_rises++;
            if (pin_q.size() == 0) begin
                check_output(1'b0, "unexpected_tck", 1, 0);
            end else begin
                e = pin_q.pop_front();
                check_output(tms == e[1], "tms", tms, e[1]);
                check_output(tdi == e[0], "tdi", tdi, e[0]);
            end
        end
        if (tck) begin
            high_len++;
        end else if (tck_prev) begin
            if (rst_n) check_output(high_len == TCK_DIV, "tck_high_len", high_len, TCK_DIV);
            high_len = 0;
        end
        if (bus.din_ready) begin
            check_output(!tck, "tck_in_fetch", tck, 0);
            check_output(din_q.size() > 0, "din_ready_unowed", din_q.size(), 1);
        end
        if (bus.dout_valid) begin
            check_output(!tck, "tck_in_push", tck, 0);
            if (stall_prev) check_output(bus.dout_data == prev_data, "dout_stable", bus.dout_data, prev_data);
            if (bus.dout_ready) begin
                if (dout_q.size() == 0) begin
                    check_output(1'b0, "unexpected_dout", bus.dout_data, 0);
                end else begin
                    ed = dout_q.pop_front();
                    check_output(bus.dout_data == ed, "dout_data", bus.dout_data, ed);
                end
            end
        end
        stall_prev = bus.dout_valid && !bus.dout_ready;
        prev_data  = bus.dout_data;
        tck_prev   = tck;
    end

    initial begin
        bit fire;
        bus.din_valid = 1'b0;
        bus.din_data  = 8'h00;
        forever begin
            @(negedge clk);
            fire = bus.din_valid && bus.din_ready;
            @(posedge clk);
            #1;
            if (fire && din_q.size() > 0) void'(din_q.pop_front());
            if (din_delay > 0) begin
                din_delay--;
                bus.din_valid = 1'b0;
            end else begin
                bus.din_valid = (din_q.size() > 0) && ($urandom_range(0, 3) != 0);
            end
            bus.din_data = (din_q.size() > 0) ? din_q[0] : 8'($urandom);
        end
    end

    initial begin
        int stall_cnt;
        stall_cnt = 0;
        bus.dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dout_stall_mode) begin
                if (bus.dout_valid) stall_cnt++;
                else stall_cnt = 0;
                bus.dout_ready = (stall_cnt > 20);
            end else begin
                bus.dout_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int start;
        bit reached;
        logic [1:0] op;
        int nb;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_nbits = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] RESET op");
        apply_stimulus(2'd0, 0, 1'b0);
        wait_done(RESET_BUSY);

        $display("[TB] SCAN_FLIP_TMS 12 bits, A5 03");
        fixed_bytes.push_back(8'hA5);
        fixed_bytes.push_back(8'h03);
        apply_stimulus(2'd3, 12, 1'b0);
        wait_done(-1);

        $display("[TB] SCAN 8 bits with dout stall, ignored cmd while busy");
        dout_stall_mode = 1'b1;
        apply_stimulus(2'd2, 8, 1'($urandom_range(0, 1)));
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'd0;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_done(-1);
        dout_stall_mode = 1'b0;

        $display("[TB] TMS_SEQ 3 bits, FE, delayed din");
        fixed_bytes.push_back(8'hFE);
        din_delay = 12;
        apply_stimulus(2'd1, 3, 1'b0);
        wait_done(-1);

        $display("[TB] zero-bit commands");
        apply_stimulus(2'd2, 0, 1'b0);
        wait_done(1);
        apply_stimulus(2'd1, 0, 1'b0);
        wait_done(1);

        $display("[TB] reset during 16-bit SCAN");
        start = tck_rises;
        apply_stimulus(2'd2, 16, 1'b0);
        reached = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (tck_rises >= start + 6) begin
                reached = 1'b1;
                break;
            end
        end
        check_output(reached, "reach_bit5", tck_rises - start, 6);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pin_q.delete();
        dout_q.delete();
        din_q.delete();
        @(negedge clk);
        check_reset_values("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(2'd0, 0, 1'b0);
        wait_done(RESET_BUSY);

        $display("[TB] random commands");
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            nb = $urandom_range(0, 20);
            apply_stimulus(op, nb, 1'($urandom_range(0, 1)));
            wait_done((op == 2'd0) ? RESET_BUSY : ((nb == 0) ? 1 : -1));
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/jtag_cmd_seq.md
JTAG_CMD_SEQ -- requirements
Module: jtag_cmd_seq

Interface
REQ-001 Parameter TCK_DIV, default 4: clk cycles per TCK half-period; legal range 1..255.
REQ-002 Parameter NBITS_W, default 16: width of the cmd_nbits field.
REQ-003 Port clk, input, 1: sole clock; all logic is rising-edge clk.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port cmd_valid, input, 1: command offered.
REQ-006 Port cmd_ready, output, 1: command accepted when both cmd_valid and cmd_ready are high.
REQ-007 Port cmd_op, input, 2: 0 = RESET, 1 = TMS_SEQ, 2 = SCAN, 3 = SCAN_FLIP_TMS.
REQ-008 Port cmd_nbits, input, NBITS_W: bit count for TMS_SEQ and SCAN ops.
REQ-009 Ports din_valid (input, 1), din_ready (output, 1), din_data (input, 8): outgoing bit-byte stream.
REQ-010 Ports dout_valid (output, 1), dout_ready (input, 1), dout_data (output, 8): captured TDO byte stream.
REQ-011 Ports tck, tms, tdi (outputs, 1 each) and tdo (input, 1): JTAG pins.
REQ-012 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 States: IDLE, FETCH, LOW, HIGH, PUSH, DONE.
REQ-014 cmd_ready is high only in IDLE.
REQ-015 On command accept, the engine latches cmd_op and cmd_nbits and clears the bit counter.
REQ-016 Each TCK bit is TCK_DIV clk cycles with tck=0 (LOW), then TCK_DIV clk cycles with tck=1 (HIGH).
REQ-017 tms and tdi update on the clk edge that enters LOW.
REQ-018 tdo is sampled on the clk edge where tck goes 0->1.
REQ-019 RESET op: 5 bits with tms=1, then 1 bit with tms=0, tdi=0; no din consumed, no dout produced; cmd_nbits is ignored.
REQ-020 TMS_SEQ op: cmd_nbits bits; tms takes the din bits LSB-first; tdi=0; no dout produced.
REQ-021 SCAN op: cmd_nbits bits; tdi takes the din bits LSB-first; tms=0.
REQ-022 SCAN_FLIP_TMS op: same as SCAN, except tms=1 on the final bit only.
REQ-023 A din byte is fetched (FETCH) before bits 0, 8, 16, and so on.
REQ-024 din_ready is high only in FETCH.
REQ-025 While din_valid is low, the engine stays in FETCH with tck held 0 and no bit clocked.
REQ-026 Final-byte bits above (cmd_nbits-1) mod 8 are ignored.
REQ-027 SCAN ops only: captured tdo bits are packed LSB-first.
REQ-028 A byte enters PUSH when 8 bits are captured or the final bit is captured; unfilled upper bits are 0.
REQ-029 In PUSH, dout_valid=1 and dout_data is stable until dout_ready; tck stays 0; no further bits are clocked.
REQ-030 Number of dout bytes per SCAN op = ceil(cmd_nbits/8).
REQ-031 cmd_nbits=0 for TMS_SEQ or SCAN: IDLE -> DONE -> IDLE; no TCK edge, no din/dout transfer.
REQ-032 DONE lasts one clk cycle, drives tms=0, tdi=0, tck=0, then returns to IDLE.
REQ-033 Back-to-back commands: the next command can be accepted the cycle after DONE.
REQ-034 Minimum per-bit cost is 2*TCK_DIV clk cycles, plus fetch/push stalls.
REQ-035 cmd_valid with cmd_ready low is ignored; the command is not latched.
REQ-036 Inputs on a handshake channel whose ready/valid is low are don't-care.

Reset
REQ-037 rst_n low, at any time including mid-command: state = IDLE.
REQ-038 rst_n low also forces tck=0, tms=0, tdi=0, cmd_ready=1, din_ready=0, dout_valid=0, dout_data=0, busy=0, counters=0.
REQ-039 Any in-flight command is discarded on reset and no partial dout byte is emitted.

Verification
REQ-040 TCK_DIV=2, RESET op -> 6 tck periods of 4 clk each; tms=1,1,1,1,1,0 at the rising edges; busy high for 25 clk (24 bit cycles plus DONE); no din/dout.
REQ-041 SCAN_FLIP_TMS, nbits=12, din 0xA5 then 0x03, tdo looped to tdi -> tdi sequence 1,0,1,0,0,1,0,1,1,1,0,0; tms=1 only on bit 11; dout 0xA5 then 0x03.
REQ-042 SCAN, nbits=8, dout_ready held low for 20 clk after dout_valid -> dout_data stable 0xXX throughout; tck stays 0; DONE follows the handshake.
REQ-043 TMS_SEQ, nbits=3, din 0xFE with din_valid delayed 10 clk -> tck stays 0 during the delay; tms=0,1,1; tdi=0; no dout.
REQ-044 SCAN, nbits=0 -> busy high exactly 1 clk; no tck edge; no din_ready or dout_valid pulse.
REQ-045 rst_n pulsed low during bit 5 of a 16-bit SCAN -> all outputs at reset values; no dout; next RESET op executes normally.
